// File: rtl/ccip_rd_arbiter_if.sv
// Bundles the requester-side handshake, the CCI-P c0 request/response
// channel and the per-requester response strobes of the read arbiter.
// master: the arbiter itself; slave: the requesters plus CCI-P shell around it.
// Ports: req_valid/req_addr/req_ready (requests), c0tx_* (outgoing reads),
//        c0rx_* (returning lines), rsp_valid/rsp_data (steered responses).
interface ccip_rd_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 42
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      c0tx_almfull;
  logic                      c0tx_valid;
  logic [ADDR_W-1:0]         c0tx_addr;
  logic [15:0]               c0tx_mdata;
  logic                      c0rx_valid;
  logic [15:0]               c0rx_mdata;
  logic [511:0]              c0rx_data;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [511:0]              rsp_data;

  modport master (
    input  req_valid, req_addr, c0tx_almfull, c0rx_valid, c0rx_mdata, c0rx_data,
    output req_ready, c0tx_valid, c0tx_addr, c0tx_mdata, rsp_valid, rsp_data
  );

  modport slave (
    output req_valid, req_addr, c0tx_almfull, c0rx_valid, c0rx_mdata, c0rx_data,
    input  req_ready, c0tx_valid, c0tx_addr, c0tx_mdata, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ccip_rd_arbiter.sv
// Round-robin arbiter sharing the CCI-P c0 read path among NUM_REQ requesters; tags mdata with requester ID.
// Latency: request->c0tx 1 cycle, c0rx response->rsp strobe 1 cycle; one grant per cycle.
// Backpressure: grants stop on c0tx_almfull, MAX_OUT in flight, or enable=0; responses never stall.
// Ports: clk, rst_n (async active-low), enable (grant/drain control), bus (ccip_rd_arbiter_if.master),
//        outstanding (reads in flight), idle (FSM in IDLE), err_bad_tag (sticky bad tag / underflow).
module ccip_rd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 42,
  parameter int MAX_OUT = 64,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W  = $clog2(MAX_OUT + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  ccip_rd_arbiter_if.master        bus,
  output logic [CNT_W-1:0]         outstanding,
  output logic                     idle,
  output logic                     err_bad_tag
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                c0tx_valid_q, c0tx_valid_d;
  logic [ADDR_W-1:0]   c0tx_addr_q, c0tx_addr_d;
  logic [ID_W-1:0]     c0tx_id_q, c0tx_id_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [511:0]        rsp_data_q, rsp_data_d;
  logic                err_q, err_d;

  logic                grant_ok;
  logic                found;
  logic [ID_W-1:0]     gnt_id;
  logic [ID_W:0]       arb_sum;
  logic [ID_W-1:0]     arb_idx;
  logic [NUM_REQ-1:0]  gnt_oh;
  logic                hs;
  logic [ID_W-1:0]     rx_id;
  logic                rx_bad;
  logic                underflow;

  // The registered request not yet counted in cnt_q still occupies a slot.
  assign grant_ok = (state_q == ST_RUN) && !bus.c0tx_almfull &&
                    (({1'b0, cnt_q} + {{CNT_W{1'b0}}, c0tx_valid_q}) < (CNT_W+1)'(MAX_OUT));

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found   = 1'b0;
    gnt_id  = '0;
    arb_sum = '0;
    arb_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (arb_sum >= (ID_W+1)'(NUM_REQ)) begin
        arb_sum = arb_sum - (ID_W+1)'(NUM_REQ);
      end
      arb_idx = arb_sum[ID_W-1:0];
      if (!found && bus.req_valid[arb_idx]) begin
        found  = 1'b1;
        gnt_id = arb_idx;
      end
    end
  end

  assign gnt_oh = (grant_ok && found) ? (NUM_REQ'(1) << gnt_id) : '0;
  assign hs     = |(bus.req_valid & gnt_oh);

  assign rx_id  = bus.c0rx_mdata[ID_W-1:0];
  assign rx_bad = (bus.c0rx_mdata[15:ID_W] != '0) || ({1'b0, rx_id} >= (ID_W+1)'(NUM_REQ));

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    c0tx_valid_d = hs;
    c0tx_addr_d  = c0tx_addr_q;
    c0tx_id_d    = c0tx_id_q;
    cnt_d        = cnt_q;
    underflow    = 1'b0;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
    state_d      = state_q;

    if (hs) begin
      c0tx_addr_d = bus.req_addr[int'(gnt_id)*ADDR_W +: ADDR_W];
      c0tx_id_d   = gnt_id;
      rr_ptr_d    = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
    end

    // Issue and return in the same cycle cancel out; a return with nothing
    // in flight is flagged instead of wrapping.
    if (c0tx_valid_q && !bus.c0rx_valid) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!c0tx_valid_q && bus.c0rx_valid) begin
      if (cnt_q == '0) begin
        underflow = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    if (bus.c0rx_valid && !rx_bad) begin
      rsp_valid_d = NUM_REQ'(1) << rx_id;
      rsp_data_d  = bus.c0rx_data;
    end

    err_d = err_q | (bus.c0rx_valid & rx_bad) | underflow;

    // DRAIN looks at the next-cycle count so idle rises right after the
    // last response is absorbed rather than one cycle later.
    unique case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN:   if (!enable) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (enable) begin
          state_d = ST_RUN;
        end else if ((cnt_d == '0) && !c0tx_valid_d) begin
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      c0tx_valid_q <= 1'b0;
      c0tx_addr_q  <= '0;
      c0tx_id_q    <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      c0tx_valid_q <= c0tx_valid_d;
      c0tx_addr_q  <= c0tx_addr_d;
      c0tx_id_q    <= c0tx_id_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      err_q        <= err_d;
    end
  end

  assign bus.req_ready  = gnt_oh;
  assign bus.c0tx_valid = c0tx_valid_q;
  assign bus.c0tx_addr  = c0tx_addr_q;
  assign bus.c0tx_mdata = {{(16-ID_W){1'b0}}, c0tx_id_q};
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign outstanding    = cnt_q;
  assign idle           = (state_q == ST_IDLE);
  assign err_bad_tag    = err_q;

endmodule

// File: tb/tb_ccip_rd_arbiter.sv
module tb_ccip_rd_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 42;
  localparam int MAX_OUT = 64;
  localparam int CNT_W   = 7;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic [CNT_W-1:0] outstanding;
  logic             idle;
  logic             err_bad_tag;

  ccip_rd_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W)) bus_if ();

  ccip_rd_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .MAX_OUT(MAX_OUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .bus         (bus_if),
    .outstanding (outstanding),
    .idle        (idle),
    .err_bad_tag (err_bad_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       mdata;
  } tx_t;

  typedef struct packed {
    logic [NUM_REQ-1:0] oh;
    logic [511:0]       data;
  } rx_t;

  tx_t txq[$];
  rx_t rxq[$];
  tx_t tx_e;
  rx_t rx_e;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int tx_cnt = 0;
  int tx_base;
  logic [511:0] d;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] addr_of(input int i, input int n);
    return {10'(i + 1), 32'(n)};
  endfunction

  task automatic drive_addrs();
    for (int i = 0; i < NUM_REQ; i++) bus_if.req_addr[i*ADDR_W +: ADDR_W] = addr_of(i, cyc);
  endtask

  // Advance to just after the next rising edge; responses are one-cycle pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    drive_addrs();
    bus_if.c0rx_valid = 1'b0;
  endtask

  // Check the combinational grant and, if one is expected, queue the request it must produce.
  task automatic expect_grant(input string tag, input logic [NUM_REQ-1:0] exp);
    int g;
    g = 0;
    #1;
    chk(tag, bus_if.req_ready, exp);
    for (int i = 0; i < NUM_REQ; i++) if (exp[i]) g = i;
    if (exp != '0) txq.push_back({addr_of(g, cyc), 16'(g)});
  endtask

  task automatic send_rsp(input logic [15:0] mdata, input logic [511:0] data, input bit good);
    bus_if.c0rx_valid = 1'b1;
    bus_if.c0rx_mdata = mdata;
    bus_if.c0rx_data  = data;
    if (good) rxq.push_back({NUM_REQ'(1) << mdata[1:0], data});
  endtask

  // Scoreboard side: every registered output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus_if.c0tx_valid === 1'b1) begin
      tx_cnt++;
      checks++;
      assert (txq.size() != 0) else begin
        errors++;
        $error("FAIL c0tx_unexpected: got addr %0h mdata %0h expected no request", bus_if.c0tx_addr, bus_if.c0tx_mdata);
      end
      if (txq.size() != 0) begin
        tx_e = txq.pop_front();
        chk("c0tx_addr", bus_if.c0tx_addr, tx_e.addr);
        chk("c0tx_mdata", bus_if.c0tx_mdata, tx_e.mdata);
      end
    end
    if (bus_if.rsp_valid !== '0) begin
      checks++;
      assert (rxq.size() != 0) else begin
        errors++;
        $error("FAIL rsp_unexpected: got rsp_valid %0h expected none", bus_if.rsp_valid);
      end
      if (rxq.size() != 0) begin
        rx_e = rxq.pop_front();
        chk("rsp_valid", bus_if.rsp_valid, rx_e.oh);
        chk("rsp_data", bus_if.rsp_data, rx_e.data);
      end
    end
  end

  initial begin
    bus_if.req_valid    = '0;
    bus_if.req_addr     = '0;
    bus_if.c0tx_almfull = 1'b0;
    bus_if.c0rx_valid   = 1'b0;
    bus_if.c0rx_mdata   = '0;
    bus_if.c0rx_data    = '0;
    enable              = 1'b0;
    rst_n               = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_idle", idle, 1'b1);
    chk("reset_outstanding", outstanding, 0);
    chk("reset_c0tx_valid", bus_if.c0tx_valid, 1'b0);
    chk("reset_rsp_valid", bus_if.rsp_valid, 0);
    chk("reset_err", err_bad_tag, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive_addrs();

    // Round-robin with every requester asking.
    enable = 1'b1;
    bus_if.req_valid = '1;
    expect_grant("idle_no_grant", '0);
    tick();
    for (int k = 0; k < 6; k++) begin
      expect_grant($sformatf("rr_%0d", k), NUM_REQ'(1) << (k % NUM_REQ));
      tick();
    end
    bus_if.req_valid = '0;
    expect_grant("rr_off", '0);
    tick();
    chk("rr_outstanding", outstanding, 6);

    // Response steering and rsp_data hold.
    d = {64{8'hA5}};
    send_rsp(16'd2, d, 1'b1);
    tick();
    chk("route_outstanding", outstanding, 5);
    tick();
    chk("rsp_hold_valid", bus_if.rsp_valid, 0);
    chk("rsp_hold_data", bus_if.rsp_data, d);

    // Issue and return in the same cycle.
    bus_if.req_valid = 4'b1000;
    expect_grant("grant3", 4'b1000);
    tick();
    bus_if.req_valid = '0;
    send_rsp(16'd0, {16{32'hDEAD_0000}}, 1'b1);
    tick();
    chk("simul_outstanding", outstanding, 5);

    // Drain: no grants while disabled, idle right after the last response.
    enable = 1'b0;
    tick();
    bus_if.req_valid = '1;
    for (int j = 0; j < 5; j++) begin
      send_rsp(16'((j + 1) % NUM_REQ), {16{32'(j + 100)}}, 1'b1);
      expect_grant($sformatf("drain_ng_%0d", j), '0);
      chk($sformatf("drain_busy_%0d", j), idle, 1'b0);
      tick();
    end
    chk("drain_idle", idle, 1'b1);
    chk("drain_outstanding", outstanding, 0);
    bus_if.req_valid = '0;

    // Outstanding cap.
    enable = 1'b1;
    bus_if.req_valid = '1;
    expect_grant("cap_idle", '0);
    tick();
    for (int k = 0; k < MAX_OUT; k++) begin
      expect_grant($sformatf("cap_%0d", k), NUM_REQ'(1) << (k % NUM_REQ));
      tick();
    end
    expect_grant("cap_full0", '0);
    tick();
    expect_grant("cap_full1", '0);
    tick();
    chk("cap_outstanding", outstanding, 64);

    // Bad tag frees a slot without a strobe; exactly one more grant follows.
    send_rsp(16'd7, {16{32'hBAD0_0007}}, 1'b0);
    expect_grant("badtag_ng", '0);
    tick();
    chk("badtag_err", err_bad_tag, 1'b1);
    chk("badtag_outstanding", outstanding, 63);
    expect_grant("cap_one_more", 4'b0001);
    tick();
    expect_grant("cap_full2", '0);
    tick();
    chk("cap_outstanding2", outstanding, 64);
    bus_if.req_valid = '0;

    // Almost-full blocks grants; only the already-registered request issues.
    for (int j = 0; j < 8; j++) begin
      send_rsp(16'(j % NUM_REQ), {16{32'(j + 200)}}, 1'b1);
      tick();
    end
    chk("af_outstanding", outstanding, 56);
    bus_if.req_valid = '1;
    expect_grant("af_pre", 4'b0010);
    tick();
    bus_if.c0tx_almfull = 1'b1;
    tx_base = tx_cnt;
    for (int k = 0; k < 10; k++) begin
      expect_grant($sformatf("af_%0d", k), '0);
      tick();
    end
    chk("af_tx_count", 32'(tx_cnt - tx_base), 1);
    bus_if.c0tx_almfull = 1'b0;
    expect_grant("af_release", 4'b0100);
    tick();
    bus_if.req_valid = '0;
    tick();

    // Enable dropped with a request present: that cycle's grant still issues.
    bus_if.req_valid = '1;
    enable = 1'b0;
    expect_grant("en_drop_last", 4'b1000);
    tick();
    expect_grant("en_drop_ng", '0);
    chk("en_drop_busy", idle, 1'b0);
    tick();
    bus_if.req_valid = '0;
    tick();
    chk("pre_rst_txq", txq.size(), 0);
    chk("pre_rst_rxq", rxq.size(), 0);

    // Asynchronous reset with reads in flight and the error flag set.
    bus_if.req_valid = '1;
    enable = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_outstanding", outstanding, 0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_err", err_bad_tag, 1'b0);
    chk("rst_req_ready", bus_if.req_ready, 0);
    chk("rst_c0tx_addr", bus_if.c0tx_addr, 0);
    chk("rst_c0tx_mdata", bus_if.c0tx_mdata, 0);
    chk("rst_rsp_data", bus_if.rsp_data, 0);
    tick();
    tick();
    rst_n = 1'b1;
    expect_grant("post_rst_idle", '0);
    tick();
    expect_grant("post_rst_first", 4'b0001);
    tick();
    bus_if.req_valid = '0;
    tick();
    chk("post_rst_outstanding", outstanding, 1);

    // Return the one read, then a stray return with nothing in flight.
    send_rsp(16'd0, {16{32'h1234_5678}}, 1'b1);
    tick();
    chk("ret_outstanding", outstanding, 0);
    chk("ret_err", err_bad_tag, 1'b0);
    send_rsp(16'd1, {16{32'h8765_4321}}, 1'b1);
    tick();
    chk("underflow_outstanding", outstanding, 0);
    chk("underflow_err", err_bad_tag, 1'b1);
    tick();
    chk("end_txq", txq.size(), 0);
    chk("end_rxq", rxq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
